// File: rtl/biquad_coeff_bank.sv
// WISHBONE coefficient staging bank: software stages per-channel biquad coefficients,
// then one commit streams them into the selected filter cores and pulses their update inputs.
module biquad_coeff_bank #(
  parameter int NCH        = 4,
  parameter int NCOEFF     = 8,
  parameter int COEFF_BITS = 18,
  parameter int ADR_BITS   = 10
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_we_i,
  input  logic [ADR_BITS-1:0]       wb_adr_i,
  input  logic [31:0]               wb_dat_i,
  input  logic [3:0]                wb_sel_i,
  output logic                      wb_ack_o,
  output logic                      wb_err_o,
  output logic                      wb_rty_o,
  output logic [31:0]               wb_dat_o,
  input  logic                      global_update_i,
  output logic [COEFF_BITS-1:0]     coeff_dat_o,
  output logic [$clog2(NCOEFF)-1:0] coeff_adr_o,
  output logic [NCH-1:0]            coeff_wr_o,
  output logic [NCH-1:0]            coeff_update_o,
  output logic                      busy_o
);

  localparam int KW   = $clog2(NCOEFF);
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int OFFW = ADR_BITS - 3;

  typedef enum logic [1:0] {IDLE, LOAD, UPDATE} state_t;

  state_t                state, next_state;
  logic [COEFF_BITS-1:0] stage [NCH][NCOEFF];
  logic [NCH-1:0]        mask;
  logic                  done, overrun, pending;
  logic [CHW-1:0]        cnt_ch;
  logic [KW-1:0]         cnt_k;
  logic [NCH-1:0]        wr_nxt, upd_nxt;

  logic [OFFW-1:0]       word_off;
  logic [OFFW-KW-1:0]    ch_sel;
  logic [KW-1:0]         k_sel;
  logic                  ctrl_hit, status_hit, coeff_hit;
  logic                  wb_req, stall, accept, wr_en, start_req, last_word;
  logic [31:0]           rd_data;
  logic                  unused_bits;

  assign word_off   = wb_adr_i[ADR_BITS-2:2];
  assign ch_sel     = word_off[OFFW-1:KW];
  assign k_sel      = word_off[KW-1:0];
  assign ctrl_hit   = !wb_adr_i[ADR_BITS-1] && (word_off == '0);
  assign status_hit = !wb_adr_i[ADR_BITS-1] && (word_off == OFFW'(1));
  assign coeff_hit  = wb_adr_i[ADR_BITS-1] && (32'(ch_sel) < NCH);

  // Coefficient writes must not race the sequencer, so they are held off (no ack) until IDLE.
  assign wb_req    = wb_cyc_i && wb_stb_i;
  assign stall     = wb_req && wb_we_i && coeff_hit && (state != IDLE);
  assign accept    = wb_req && !wb_ack_o && !stall;
  assign wr_en     = accept && wb_we_i && wb_sel_i[0];
  assign start_req = wr_en && ctrl_hit && wb_dat_i[31];
  assign last_word = (cnt_ch == CHW'(NCH-1)) && (cnt_k == KW'(NCOEFF-1));

  assign wb_err_o    = 1'b0;
  assign wb_rty_o    = 1'b0;
  assign busy_o      = (state != IDLE);
  assign unused_bits = ^{wb_sel_i[3:1], wb_adr_i[1:0]};

  always_comb begin
    rd_data = '0;
    if (ctrl_hit)
      rd_data = 32'(mask);
    else if (status_hit)
      rd_data = {29'd0, overrun, done, busy_o};
    else if (coeff_hit)
      rd_data = 32'(stage[ch_sel[CHW-1:0]][k_sel]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_req) next_state = LOAD;
      LOAD:    if (last_word) next_state = UPDATE;
      UPDATE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    wr_nxt  = '0;
    upd_nxt = '0;
    case (state)
      LOAD:    wr_nxt  = mask[cnt_ch] ? (NCH'(1) << cnt_ch) : '0;
      UPDATE:  upd_nxt = mask;
      IDLE:    if (global_update_i || pending) upd_nxt = '1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      coeff_wr_o     <= '0;
      coeff_update_o <= '0;
      coeff_dat_o    <= '0;
      coeff_adr_o    <= '0;
      cnt_ch         <= '0;
      cnt_k          <= '0;
      pending        <= 1'b0;
    end else begin
      coeff_wr_o     <= wr_nxt;
      coeff_update_o <= upd_nxt;
      if (state == LOAD) begin
        coeff_dat_o <= stage[cnt_ch][cnt_k];
        coeff_adr_o <= cnt_k;
        cnt_k       <= cnt_k + 1'b1;
        if (&cnt_k) cnt_ch <= cnt_ch + 1'b1;
      end else begin
        cnt_ch <= '0;
        cnt_k  <= '0;
      end
      // Requests arriving mid-commit collapse into one all-ones pulse back in IDLE.
      if (state == IDLE)
        pending <= 1'b0;
      else if (global_update_i)
        pending <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      mask     <= '0;
      done     <= 1'b0;
      overrun  <= 1'b0;
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < NCOEFF; k++)
          stage[c][k] <= '0;
    end else begin
      wb_ack_o <= accept;
      if (accept) wb_dat_o <= wb_we_i ? 32'd0 : rd_data;
      if (wr_en && coeff_hit)
        stage[ch_sel[CHW-1:0]][k_sel] <= wb_dat_i[COEFF_BITS-1:0];
      if (wr_en && ctrl_hit && state == IDLE)
        mask <= wb_dat_i[NCH-1:0];
      if (wr_en && status_hit && wb_dat_i[1]) done <= 1'b0;
      if (wr_en && status_hit && wb_dat_i[2]) overrun <= 1'b0;
      if (start_req && state == IDLE) done <= 1'b0;
      if (start_req && state != IDLE) overrun <= 1'b1;
      if (state == UPDATE) done <= 1'b1;
    end
  end

endmodule

// File: doc/biquad_coeff_bank.md
Name: biquad_coeff_bank

Overview:
WISHBONE-controlled coefficient staging bank for up to NCH biquad channels, all in a single clock domain.
Software writes coefficients into per-channel staging RAM, then issues one commit. A sequencer streams the staged words into the selected filter cores and pulses their update inputs together.
Supports readback of all staged values and status. global_update_i is honoured even while a commit is in progress.
Sits between the WISHBONE interconnect and an array of biquad filter cores.

Parameters:
NCH, 4, number of channels (1..16)
NCOEFF, 8, coefficients per channel (power of 2, >=2)
COEFF_BITS, 18, coefficient width (<=32)
ADR_BITS, 10, WISHBONE address width; must satisfy ADR_BITS >= 3+clog2(NCH)+clog2(NCOEFF)

Ports:
clk_i  in  1  clock, all logic
rst_ni  in  1  asynchronous active-low reset
wb_cyc_i  in  1  WISHBONE cycle
wb_stb_i  in  1  WISHBONE strobe
wb_we_i  in  1  write enable
wb_adr_i  in  ADR_BITS  byte address, bits[1:0] ignored
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte selects; a write takes effect only if wb_sel_i[0]=1
wb_ack_o  out  1  acknowledge
wb_err_o  out  1  tied 0
wb_rty_o  out  1  tied 0
wb_dat_o  out  32  read data
global_update_i  in  1  request update of all channels
coeff_dat_o  out  COEFF_BITS  coefficient to cores
coeff_adr_o  out  clog2(NCOEFF)  coefficient index
coeff_wr_o  out  NCH  per-channel write strobe
coeff_update_o  out  NCH  per-channel update pulse
busy_o  out  1  sequencer not IDLE

Behaviour:
- Reset (async assert on rst_ni=0, sync release): all outputs 0, FSM=IDLE, staging RAM=0, mask=0, status flags=0.
- Address map:
  - 0x00 CTRL. Write: bits[NCH-1:0]=mask, bit31=start. Read: {start=0, mask}.
  - 0x04 STATUS. Read-only: bit0 busy, bit1 done (sticky), bit2 overrun (sticky). Writing 1 to bit1 or bit2 clears that flag.
  - Coefficient space at base 1<<(ADR_BITS-1), word offset (ch<<clog2(NCOEFF))+k. Reads return zero-extended coefficient. Writes take wb_dat_i[COEFF_BITS-1:0].
  - ch>=NCH or other unmapped addresses: reads return 0, writes are ignored, access is still acked.
- WISHBONE timing:
  - wb_ack_o asserts one cycle after cyc&stb and is held for one cycle; the next ack needs stb to be seen again after the ack cycle.
  - Read data is valid with ack.
  - Exception: a coefficient-space write while busy gets no ack and no write until the FSM returns to IDLE; it is then acked and written.
- FSM:
  - IDLE: a CTRL write with bit31=1 latches the mask, clears done, and enters LOAD on the next cycle.
  - LOAD: counter c=0..NCH-1 (outer), k=0..NCOEFF-1 (inner), one word per cycle, NCH*NCOEFF cycles total. Each cycle drives coeff_dat_o=stage[c][k], coeff_adr_o=k, and coeff_wr_o=(mask[c]?1<<c:0). Unmasked channels still consume cycles, so latency is deterministic. The last word goes to UPDATE.
  - UPDATE: one cycle, coeff_update_o=mask, then set done and go to IDLE.
  - A start while not IDLE is ignored (acked) and sets overrun. A CTRL write without bit31 updates the mask only when IDLE.
  - Mask=0 still runs the full sequence with no strobes and an update of 0.
- global_update_i:
  - In IDLE: coeff_update_o={NCH{1}} on the next cycle, a one-cycle pulse.
  - During LOAD/UPDATE: latched in a pending flag. After UPDATE, IDLE emits an all-ones pulse on the first IDLE cycle, then clears the flag.
  - Multiple requests while pending collapse into one pulse.
  - Simultaneous with start in IDLE: the update pulse issues first, and LOAD begins the same cycle.
- coeff_wr_o and coeff_update_o are registered outputs. coeff_dat_o/coeff_adr_o hold their last value outside LOAD.
- Reset mid-LOAD: sequence aborted, no update pulse, staged coefficients cleared.

Test Plan:
- After reset, read 0x04 -> 0x0; read 0x200 -> 0x0; all core outputs 0.
- Write 0x200=0x1ABCD and 0x21C=0x3FFFF, then read back -> 0x1ABCD and 0x3FFFF; write 0x200 with sel=0 -> value unchanged.
- Stage ch0 k0..7=1..8 and ch2 k0..7=0x11..0x18. Write CTRL=0x80000005 -> busy_o for 33 cycles; coeff_wr_o=0x1 for 8 cycles with data 1..8 and adr 0..7; 8 cycles of 0; 8 cycles of 0x4 with data 0x11..0x18; 8 cycles of 0; then coeff_update_o=0x5 for one cycle; STATUS=0x2.
- Assert global_update_i in mid-LOAD -> no pulse during LOAD; update=0x5 at end, then 0xF on the next cycle; in IDLE, a global pulse -> 0xF one cycle later.
- Coefficient write during LOAD -> ack delayed until busy_o falls, value written afterwards; a second start during LOAD -> STATUS bit2=1, no extra sequence.
- Pull rst_ni low mid-LOAD -> outputs 0 immediately; no coeff_update_o after release; staged reads 0.
